// File: rtl/decode_instr_assembler_pkg.sv
// Shared constants, state encoding and payload type for the instruction assembler.
package decode_instr_assembler_pkg;

    localparam int unsigned MAX_BYTES = 11;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned INSTR_W   = MAX_BYTES * BYTE_W;
    localparam int unsigned CNT_W     = 4;

    localparam logic [BYTE_W-1:0] ESCAPE_BYTE = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_EMIT    = 2'd3
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               is_2byte;
        logic [CNT_W-1:0]   len;
        logic               err;
    } instr_word_t;

endpackage

// File: rtl/decode_byte_packer.sv
// Byte-lane buffer for the unescaped instruction plus its fill count.
module decode_byte_packer
    import decode_instr_assembler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [BYTE_W-1:0]  wr_byte_i,
    output logic [INSTR_W-1:0] buf_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [INSTR_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Writes past the last lane are ignored so count saturates at MAX_BYTES.
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        if (clr_i) begin
            buf_d   = '0;
            count_d = '0;
        end else if (wr_en_i && (count_q < CNT_W'(MAX_BYTES))) begin
            for (int unsigned k = 0; k < MAX_BYTES; k++) begin
                if (count_q == CNT_W'(k)) begin
                    buf_d[k*BYTE_W +: BYTE_W] = wr_byte_i;
                end
            end
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
        end
    end

    assign buf_o   = buf_q;
    assign count_o = count_q;

endmodule

// File: rtl/decode_instr_assembler.sv
// Byte-serial x86 instruction assembler: strips a leading 0x0F escape and
// presents the packed unescaped word to the phase-2 decoder.
module decode_instr_assembler
    import decode_instr_assembler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BYTE_W-1:0]  in_byte,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_is_2byte,
    output logic [CNT_W-1:0]   out_len,
    output logic               out_err
);

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               is_2byte_q;
    logic               err_q;
    logic               byte_acc;
    logic               out_acc;
    logic               is_esc;
    logic               full;
    logic               pk_wr_en;
    logic [INSTR_W-1:0] pk_buf;
    logic [CNT_W-1:0]   pk_count;

    assign byte_acc = in_valid & in_ready_q;
    assign out_acc  = out_valid_q & out_ready;
    assign is_esc   = (in_byte == ESCAPE_BYTE);
    assign full     = (pk_count == CNT_W'(MAX_BYTES));

    // Escape in first position and overflow bytes never reach the buffer.
    assign pk_wr_en = byte_acc &
                      (((state_q == ST_IDLE) & ~is_esc) |
                       ((state_q == ST_COLLECT) & ~full));

    decode_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (out_acc),
        .wr_en_i   (pk_wr_en),
        .wr_byte_i (in_byte),
        .buf_o     (pk_buf),
        .count_o   (pk_count)
    );

    // Handshake flags are registered alongside each state transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            is_2byte_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_acc) begin
                        if (is_esc) begin
                            is_2byte_q <= 1'b1;
                            if (in_last) err_q <= 1'b1;
                        end
                        if (in_last) begin
                            state_q     <= ST_EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (byte_acc) begin
                        if (full) err_q <= 1'b1;
                        if (in_last) begin
                            state_q     <= ST_EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else if (full) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (byte_acc && in_last) begin
                        state_q     <= ST_EMIT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_acc) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        is_2byte_q  <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = pk_buf;
    assign out_is_2byte = is_2byte_q;
    assign out_len      = pk_count;
    assign out_err      = err_q;

endmodule

// File: tb/tb_decode_instr_assembler.sv
// Scoreboard bench for decode_instr_assembler: expected words queued at stimulus time.
module tb_decode_instr_assembler;
    import decode_instr_assembler_pkg::*;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_byte;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [87:0]        out_instr;
    logic               out_is_2byte;
    logic [3:0]         out_len;
    logic               out_err;

    int checks = 0;
    int errors = 0;
    instr_word_t sb[$];

    decode_instr_assembler dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_is_2byte (out_is_2byte),
        .out_len      (out_len),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every accepted output is compared with the oldest expectation.
    always @(negedge clk) begin
        instr_word_t got;
        instr_word_t exp;
        if (!rst && out_valid && out_ready) begin
            got = {out_instr, out_is_2byte, out_len, out_err};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got instr=%h is2=%0b len=%0d err=%0b, required none",
                         got.instr, got.is_2byte, got.len, got.err);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL output_word: got instr=%h is2=%0b len=%0d err=%0b, required instr=%h is2=%0b len=%0d err=%0b",
                             got.instr, got.is_2byte, got.len, got.err,
                             exp.instr, exp.is_2byte, exp.len, exp.err);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_sb();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
        end
        checks++;
        if (out_instr !== 88'h0 || out_len !== 4'd0 || out_is_2byte !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: instr=%h len=%0d is2=%0b err=%0b, required all zero",
                     out_instr, out_len, out_is_2byte, out_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        sb.push_back('{instr: 88'hD889, is_2byte: 1'b0, len: 4'd2, err: 1'b0});
        send_byte(8'h89, 1'b0);
        send_byte(8'hD8, 1'b1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: out_valid=%0b, required 1", out_valid);
        end
        drain_sb();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_escape();
        sb.push_back('{instr: 88'hC1AF, is_2byte: 1'b1, len: 4'd2, err: 1'b0});
        send_byte(8'h0F, 1'b0);
        send_byte(8'hAF, 1'b0);
        send_byte(8'hC1, 1'b1);
        drain_sb();
    endtask

    task automatic test_second_escape();
        sb.push_back('{instr: 88'h0F0F, is_2byte: 1'b1, len: 4'd2, err: 1'b0});
        send_byte(8'h0F, 1'b0);
        send_byte(8'h0F, 1'b0);
        send_byte(8'h0F, 1'b1);
        drain_sb();
    endtask

    task automatic test_overlength();
        logic [87:0] w = '0;
        for (int k = 0; k < 11; k++) w[k*8 +: 8] = 8'(k + 1);
        sb.push_back('{instr: w, is_2byte: 1'b0, len: 4'd11, err: 1'b1});
        for (int i = 1; i <= 13; i++) begin
            send_byte(8'(i), (i == 13));
            if (i == 12) begin
                checks++;
                if (dut.state_q !== ST_DRAIN || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL overlength_drain: state=%0d in_ready=%0b, required %0d 1",
                             dut.state_q, in_ready, ST_DRAIN);
                end
            end
        end
        drain_sb();
    endtask

    task automatic test_escape_only();
        sb.push_back('{instr: 88'h0, is_2byte: 1'b1, len: 4'd0, err: 1'b1});
        send_byte(8'h0F, 1'b1);
        drain_sb();
    endtask

    task automatic test_back_to_back();
        instr_word_t got;
        instr_word_t held;
        held = '{instr: 88'hC3, is_2byte: 1'b0, len: 4'd1, err: 1'b0};
        out_ready = 1'b0;
        sb.push_back(held);
        send_byte(8'hC3, 1'b1);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        in_last  = 1'b1;
        sb.push_back('{instr: 88'h55, is_2byte: 1'b0, len: 4'd1, err: 1'b0});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = {out_instr, out_is_2byte, out_len, out_err};
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== held) begin
                errors++;
                $display("FAIL hold_cycle%0d: in_ready=%0b out_valid=%0b instr=%h len=%0d, required 0 1 %h %0d",
                         c, in_ready, out_valid, got.instr, got.len, held.instr, held.len);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_idle: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL next_accept: out_valid=%0b, required 1", out_valid);
        end
        drain_sb();
    endtask

    task automatic test_mid_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_instr !== 88'h0 || out_len !== 4'd0 ||
            out_is_2byte !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%0b out_valid=%0b instr=%h len=%0d, required 1 0 0 0",
                     in_ready, out_valid, out_instr, out_len);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{instr: 88'h90, is_2byte: 1'b0, len: 4'd1, err: 1'b0});
        send_byte(8'h90, 1'b1);
        drain_sb();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_escape();
        test_second_escape();
        test_overlength();
        test_escape_only();
        test_back_to_back();
        test_mid_reset();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_instr_assembler.md
Name: decode_instr_assembler

Overview:
- Sequential front-end for the phase-2 opcode decoder.
- Accepts a raw x86 instruction one byte per cycle over a valid/ready stream and strips a single leading 0x0F escape.
- Packs the remaining bytes into the 88-bit unescaped instruction word, with `is_2byte` and a length, then holds them stable for the downstream decode stage until they are consumed.
- Sits between the instruction byte source and the decode_opc_phase2 / operand decode stages.

Parameters:
- MAX_BYTES, 11: maximum unescaped bytes stored; the output word width is MAX_BYTES*8 = 88.
- ESCAPE_BYTE, 8'h0F: two-byte opcode escape value, recognised only as the first byte.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  block accepts in_byte this cycle.
- in_byte  input  8  raw instruction byte.
- in_last  input  1  in_byte is the final byte of the instruction.
- out_valid  output  1  assembled instruction available.
- out_ready  input  1  downstream consumes the output this cycle.
- out_instr  output  88  unescaped instruction; byte k at [8k+7:8k]; unfilled bytes are zero.
- out_is_2byte  output  1  the instruction began with ESCAPE_BYTE.
- out_len  output  4  number of stored unescaped bytes (0..11).
- out_err  output  1  overlength instruction, or escape-only instruction.

Behaviour:
- Reset (async, any state, including mid-instruction or mid-emit): state=IDLE, buffer=0, count=0, is_2byte=0, err=0.
  - All outputs read 0, except in_ready=1.
  - Any partially collected instruction is discarded.
- Byte accept = in_valid & in_ready.
- Output accept = out_valid & out_ready.
- States: IDLE, COLLECT, DRAIN, EMIT.
- in_ready is 1 in IDLE/COLLECT/DRAIN and 0 in EMIT. out_valid is 1 only in EMIT.
- IDLE, on byte accept:
  - If in_byte==ESCAPE_BYTE: set is_2byte and store nothing. Go to EMIT with err=1 if in_last, else COLLECT.
  - Otherwise: store at byte 0 and set count=1. Go to EMIT if in_last, else COLLECT.
- COLLECT, on byte accept with count<MAX_BYTES:
  - Store at byte[count] and increment count.
  - A second ESCAPE_BYTE is stored as ordinary data; there is no three-byte escape handling.
  - in_last goes to EMIT; otherwise stay in COLLECT.
- COLLECT, on byte accept with count==MAX_BYTES:
  - Drop the byte and set err=1.
  - in_last goes to EMIT, else DRAIN.
- DRAIN:
  - Accept and drop bytes.
  - On an accepted in_last byte, go to EMIT.
- EMIT:
  - out_instr, out_is_2byte, out_len and out_err are registered and held stable while out_valid=1 and out_ready=0.
  - On output accept: clear buffer, count, is_2byte and err; go to IDLE next cycle.
- Latency: out_valid asserts the cycle after the in_last byte is accepted.
- Minimum throughput is one bubble per instruction: there is no same-cycle accept of a new first byte during EMIT.
- in_valid without an accept (in_ready=0) has no effect. in_byte and in_last are ignored when in_valid=0.
- Buffer write index is count (0..10). count never exceeds MAX_BYTES.

Decomposition:
- Shared defines/package:
  - ESCAPE_BYTE value.
  - MAX_BYTES.
  - Instruction-word width (88).
  - State encoding localparams (IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2, EMIT=2'd3).
- One natural sub-module: decode_byte_packer.
  - Holds the 88-bit buffer and the count register, with byte-lane write enable and synchronous clear.
  - The FSM and handshake logic stay in the top.

Test Plan:
- Bytes 89 D8, last on D8; out_ready=1 → next cycle out_valid=1, out_instr[15:0]=16'hD889, upper bits 0, out_len=2, out_is_2byte=0, out_err=0; IDLE the following cycle.
- Bytes 0F AF C1 → out_instr[15:0]=16'hC1AF, out_is_2byte=1, out_len=2, out_err=0.
- 13 bytes 01..0D, last on 0D → out_instr bytes 01..0B, out_len=11, out_err=1; bytes 0C/0D dropped, DRAIN visited.
- Single byte 0F with in_last → out_valid, out_len=0, out_is_2byte=1, out_err=1, out_instr=0.
- Instruction C3 (last); out_ready held 0 for 5 cycles while in_valid=1 → in_ready=0 and outputs constant throughout; accept on cycle 6; next byte accepted the cycle after.
- rst pulsed after 3 bytes of a 5-byte instruction → outputs zero, in_ready=1 immediately; a fresh instruction 90 assembles as out_instr=88'h90, out_len=1.
